// File: rtl/sd_rx_helpers.sv
// SD-card SPI receive helpers: word deserializer, cycle waiter and push-button debouncer.
// Define SD_RX_LSB_FIRST_EN for LSB-first word assembly in the deserializer.
module sd_rx_helpers #(
  parameter int DATA_LENGTH   = 4096,
  parameter int WORD_SIZE     = 8,
  parameter int COUNTER_SIZE  = 8,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    des_start,
  input  logic                    des_data_in,
  output logic [WORD_SIZE-1:0]    des_data_out,
  output logic                    des_busy,
  output logic                    des_rco,
  input  logic                    wait_start,
  input  logic [COUNTER_SIZE-1:0] wait_count_to,
  output logic                    wait_busy,
  input  logic                    pb_in,
  output logic                    pb_state,
  output logic                    pb_down,
  output logic                    pb_up
);

  localparam int BCW = $clog2(DATA_LENGTH + 1);
  localparam int WCW = $clog2(WORD_SIZE + 1);

  typedef enum logic {D_IDLE, D_SHIFT} des_state_t;
  typedef enum logic {W_IDLE, W_COUNT} wait_state_t;

  des_state_t                 dst_q, dst_d;
  logic [BCW-1:0]             bcnt_q, bcnt_d;
  logic [WCW-1:0]             wbit_q, wbit_d;
  logic [WORD_SIZE-1:0]       sh_q, sh_d, sh_next, partial;
  logic [WORD_SIZE-1:0]       dout_q, dout_d;
  logic                       rco_q, rco_d;

  wait_state_t                wst_q, wst_d;
  logic [COUNTER_SIZE-1:0]    wlen_q, wlen_d, tcnt_q, tcnt_d;

  logic                       sync1_q, sync2_q;
  logic                       pbst_q, pbst_d, down_q, down_d, up_q, up_d;
  logic [DEBOUNCE_BITS-1:0]   pbcnt_q, pbcnt_d, pbcnt_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dst_q   <= D_IDLE;
      bcnt_q  <= '0;
      wbit_q  <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      rco_q   <= 1'b0;
      wst_q   <= W_IDLE;
      wlen_q  <= '0;
      tcnt_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pbst_q  <= 1'b0;
      pbcnt_q <= '0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      dst_q   <= dst_d;
      bcnt_q  <= bcnt_d;
      wbit_q  <= wbit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      rco_q   <= rco_d;
      wst_q   <= wst_d;
      wlen_q  <= wlen_d;
      tcnt_q  <= tcnt_d;
      sync1_q <= pb_in;
      sync2_q <= sync1_q;
      pbst_q  <= pbst_d;
      pbcnt_q <= pbcnt_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  // The shift register is cleared at run start and after every word, so a
  // partial final word arrives already zero-padded.
  always_comb begin
`ifdef SD_RX_LSB_FIRST_EN
    sh_next = {des_data_in, sh_q[WORD_SIZE-1:1]};
    partial = sh_next >> (WCW'(WORD_SIZE - 1) - wbit_q);
`else
    sh_next = {sh_q[WORD_SIZE-2:0], des_data_in};
    partial = sh_next;
`endif
    dst_d  = dst_q;
    bcnt_d = bcnt_q;
    wbit_d = wbit_q;
    sh_d   = sh_q;
    dout_d = dout_q;
    rco_d  = 1'b0;
    case (dst_q)
      D_IDLE: begin
        if (des_start) begin
          dst_d  = D_SHIFT;
          bcnt_d = '0;
          wbit_d = '0;
          sh_d   = '0;
        end
      end
      D_SHIFT: begin
        sh_d   = sh_next;
        bcnt_d = bcnt_q + BCW'(1);
        wbit_d = wbit_q + WCW'(1);
        if (wbit_q == WCW'(WORD_SIZE - 1)) begin
          dout_d = sh_next;
          rco_d  = 1'b1;
          wbit_d = '0;
          sh_d   = '0;
        end
        if (bcnt_q == BCW'(DATA_LENGTH - 1)) begin
          dst_d = D_IDLE;
          if (wbit_q != WCW'(WORD_SIZE - 1)) begin
            dout_d = partial;
            rco_d  = 1'b1;
          end
        end
      end
      default: dst_d = D_IDLE;
    endcase
  end

  always_comb begin
    wst_d  = wst_q;
    wlen_d = wlen_q;
    tcnt_d = tcnt_q;
    case (wst_q)
      W_IDLE: begin
        if (wait_start && (wait_count_to != '0)) begin
          wst_d  = W_COUNT;
          wlen_d = wait_count_to;
          tcnt_d = '0;
        end
      end
      W_COUNT: begin
        if (tcnt_q == (wlen_q - COUNTER_SIZE'(1))) wst_d = W_IDLE;
        else                                       tcnt_d = tcnt_q + COUNTER_SIZE'(1);
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    pbcnt_inc = pbcnt_q + DEBOUNCE_BITS'(1);
    pbst_d    = pbst_q;
    pbcnt_d   = pbcnt_q;
    down_d    = 1'b0;
    up_d      = 1'b0;
    if (sync2_q == pbst_q) begin
      pbcnt_d = '0;
    end else if (&pbcnt_inc) begin
      pbst_d  = ~pbst_q;
      pbcnt_d = '0;
      down_d  = ~pbst_q;
      up_d    = pbst_q;
    end else begin
      pbcnt_d = pbcnt_inc;
    end
  end

  assign des_data_out = dout_q;
  assign des_busy     = (dst_q == D_SHIFT);
  assign des_rco      = rco_q;
  assign wait_busy    = (wst_q == W_COUNT);
  assign pb_state     = pbst_q;
  assign pb_down      = down_q;
  assign pb_up        = up_q;

endmodule

// File: tb/tb_sd_rx_helpers.sv
// Scoreboard bench for sd_rx_helpers: random stimulus, reference model, async reset checks.
module tb_sd_rx_helpers;

  localparam int NCYC = 3000;

  typedef struct {
    int         inst;
    int         cyc;
    logic [7:0] w;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] des_start_v = '0;
  logic [1:0] des_data_v  = '0;
  logic [1:0] des_busy_v;
  logic [1:0] des_rco_v;
  logic [7:0] dout_v [2];
  logic       wait_start = 1'b0;
  logic [7:0] wait_count_to = '0;
  logic       wait_busy, wait_busy_1;
  logic       pb_in = 1'b0;
  logic       pb_state, pb_down, pb_up;
  logic       pb_state_1, pb_down_1, pb_up_1;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t expq[$];
  logic pbq[$];
  int   d_rs [2] = '{-1000, -1000};
  bit   dbits [2][17];
  int   w_rs = -1000;
  int   w_len = 0;

  sd_rx_helpers #(.DATA_LENGTH(16), .WORD_SIZE(8), .COUNTER_SIZE(8), .DEBOUNCE_BITS(4)) u0 (
    .clock(clock), .reset(reset),
    .des_start(des_start_v[0]), .des_data_in(des_data_v[0]), .des_data_out(dout_v[0]),
    .des_busy(des_busy_v[0]), .des_rco(des_rco_v[0]),
    .wait_start(wait_start), .wait_count_to(wait_count_to), .wait_busy(wait_busy),
    .pb_in(pb_in), .pb_state(pb_state), .pb_down(pb_down), .pb_up(pb_up)
  );

  sd_rx_helpers #(.DATA_LENGTH(7), .WORD_SIZE(8), .COUNTER_SIZE(8), .DEBOUNCE_BITS(4)) u1 (
    .clock(clock), .reset(reset),
    .des_start(des_start_v[1]), .des_data_in(des_data_v[1]), .des_data_out(dout_v[1]),
    .des_busy(des_busy_v[1]), .des_rco(des_rco_v[1]),
    .wait_start(1'b0), .wait_count_to(8'd0), .wait_busy(wait_busy_1),
    .pb_in(1'b0), .pb_state(pb_state_1), .pb_down(pb_down_1), .pb_up(pb_up_1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int dlen(input int i);
    return (i == 0) ? 16 : 7;
  endfunction

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    pbq.push_back(1'b0);
    pbq.push_back(1'b0);
    fork
      begin : driver
        int c, k, f, m, n_len, cnt;
        logic st, b, ws, pb_lvl;
        logic [7:0] w;
        int pb_left;
        pb_lvl  = 1'b0;
        pb_left = 0;
        for (int n = 0; n < NCYC; n++) begin
          @(negedge clock);
          c = cyc;
          for (int i = 0; i < 2; i++) begin
            n_len = dlen(i);
            st = (n < NCYC - 120) && ($urandom_range(0, 5) == 0);
            b  = 1'($urandom_range(0, 1));
            if (st && !(c >= d_rs[i] && c < d_rs[i] + n_len)) d_rs[i] = c + 1;
            k = c - d_rs[i] + 1;
            if (k >= 1 && k <= n_len) begin
              dbits[i][k] = b;
              if ((k % 8 == 0) || (k == n_len)) begin
                f = ((k - 1) / 8) * 8 + 1;
                m = k - f + 1;
                w = '0;
                for (int t = 0; t < m; t++) begin
`ifdef SD_RX_LSB_FIRST_EN
                  w[t] = dbits[i][f + t];
`else
                  w[m - 1 - t] = dbits[i][f + t];
`endif
                end
                expq.push_back('{i, c + 1, w});
              end
            end
            des_start_v[i] = st;
            des_data_v[i]  = b;
          end
          ws  = (n < NCYC - 120) && ((n == 2) || ($urandom_range(0, 7) == 0));
          cnt = (n == 2 || $urandom_range(0, 9) == 0) ? 80 : $urandom_range(0, 20);
          if (ws && cnt != 0 && !(c >= w_rs && c < w_rs + w_len)) begin
            w_rs  = c + 1;
            w_len = cnt;
          end
          wait_start    = ws;
          wait_count_to = 8'(cnt);
          if (n < 40) begin
            pb_lvl = 1'((n / 5) % 2);
          end else begin
            if (pb_left == 0) begin
              pb_lvl  = ~pb_lvl;
              pb_left = $urandom_range(1, 24);
            end
            pb_left--;
          end
          pb_in = pb_lvl;
          pbq.push_back(pb_lvl);
        end
      end
      begin : monitor
        int c, hit, run;
        logic m_pb, e_dn, e_up, x;
        logic [7:0] last_w [2];
        last_w[0] = '0;
        last_w[1] = '0;
        m_pb = 1'b0;
        run  = 0;
        for (int n = 0; n < NCYC; n++) begin
          @(negedge clock);
          c = cyc;
          for (int i = 0; i < 2; i++) begin
            chk($sformatf("des_busy[%0d]", i), 32'(des_busy_v[i]),
                32'(c >= d_rs[i] && c < d_rs[i] + dlen(i)));
            hit = -1;
            foreach (expq[j]) if (expq[j].inst == i && expq[j].cyc == c) hit = j;
            if (hit >= 0) begin
              chk($sformatf("des_rco[%0d]", i), 32'(des_rco_v[i]), 32'd1);
              chk($sformatf("des_data_out[%0d]", i), 32'(dout_v[i]), 32'(expq[hit].w));
              last_w[i] = expq[hit].w;
              expq.delete(hit);
            end else begin
              chk($sformatf("des_rco_idle[%0d]", i), 32'(des_rco_v[i]), 32'd0);
              chk($sformatf("des_data_hold[%0d]", i), 32'(dout_v[i]), 32'(last_w[i]));
            end
          end
          chk("wait_busy", 32'(wait_busy), 32'(c >= w_rs && c < w_rs + w_len));
          chk("u1_idle_side", 32'({wait_busy_1, pb_state_1, pb_down_1, pb_up_1}), 32'd0);
          e_dn = 1'b0;
          e_up = 1'b0;
          if (n > 0) begin
            x = pbq.pop_front();
            if (x != m_pb) begin
              run++;
              if (run == 15) begin
                m_pb = x;
                run  = 0;
                e_dn = x;
                e_up = ~x;
              end
            end else begin
              run = 0;
            end
          end
          chk("pb_state", 32'(pb_state), 32'(m_pb));
          chk("pb_down", 32'(pb_down), 32'(e_dn));
          chk("pb_up", 32'(pb_up), 32'(e_up));
        end
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      end
    join

    des_start_v   = '0;
    des_data_v    = '0;
    wait_start    = 1'b0;
    @(negedge clock);
    pb_in         = 1'b1;
    wait_start    = 1'b1;
    wait_count_to = 8'd80;
    @(negedge clock);
    wait_start    = 1'b0;
    repeat (28) @(negedge clock);
    des_start_v[0] = 1'b1;
    des_data_v[0]  = 1'b1;
    @(negedge clock);
    des_start_v[0] = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre_rst des_busy", 32'(des_busy_v[0]), 32'd1);
    chk("pre_rst des_data_out", 32'(dout_v[0]), 32'hFF);
    chk("pre_rst wait_busy", 32'(wait_busy), 32'd1);
    chk("pre_rst pb_state", 32'(pb_state), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst des_busy", 32'(des_busy_v[0]), 32'd0);
    chk("rst des_rco", 32'(des_rco_v[0]), 32'd0);
    chk("rst des_data_out", 32'(dout_v[0]), 32'd0);
    chk("rst wait_busy", 32'(wait_busy), 32'd0);
    chk("rst pb_state", 32'(pb_state), 32'd0);
    #4 reset = 1'b0;
    pb_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_rst wait_busy", 32'(wait_busy), 32'd0);
    chk("post_rst des_busy", 32'(des_busy_v[0]), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_rx_helpers.md
Name: sd_rx_helpers

Overview:
- Timing/receive support block for the SD-card SPI reader. Runs on the SPI bit clock.
- Contains three independent sub-functions sharing one clock and reset:
  - word deserializer with word-complete strobe (R1 response and 512-byte data block capture, feeding the FIFO);
  - programmable cycle waiter (80-clock SPI-mode init, CRC skip);
  - push-button debouncer for the start/reset buttons.

Parameters:
- DATA_LENGTH, 4096: total bits captured per deserializer run.
- WORD_SIZE, 8: bits per output word.
- COUNTER_SIZE, 8: waiter count width.
- DEBOUNCE_BITS, 16: debouncer counter width.

Ports:
- clock  in  1  single rising-edge clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- des_start  in  1  start a capture run; sampled only when idle.
- des_data_in  in  1  serial input (MISO).
- des_data_out  out  WORD_SIZE  last completed word.
- des_busy  out  1  capture run in progress.
- des_rco  out  1  one-cycle strobe: des_data_out just updated.
- wait_start  in  1  start a wait; sampled only when idle.
- wait_count_to  in  COUNTER_SIZE  wait length in cycles.
- wait_busy  out  1  wait in progress.
- pb_in  in  1  raw button, active-high, asynchronous.
- pb_state  out  1  debounced level.
- pb_down  out  1  one-cycle pulse on debounced 0->1.
- pb_up  out  1  one-cycle pulse on debounced 1->0.

Behaviour:
- Reset (async): all outputs 0; all counters, shift registers and sync flops cleared. Reset mid-operation aborts any run or wait immediately.
- Deserializer, two states, IDLE and SHIFT:
  - IDLE: on an edge with des_start=1, go to SHIFT; des_busy=1 from that edge. Bit counter and word-bit counter cleared.
  - SHIFT samples des_data_in on each of the next DATA_LENGTH edges; des_busy is high exactly DATA_LENGTH cycles.
  - Shifting is MSB-first: shift left, new bit enters bit 0.
  - When WORD_SIZE bits accumulate: on that same edge, des_data_out <= assembled word, des_rco=1 for one cycle, word-bit counter restarts.
  - On the edge sampling bit DATA_LENGTH, des_busy drops and the state returns to IDLE.
  - If bits remain in an incomplete word at that point, emit them right-aligned and zero-padded, with des_rco, on that same edge. Example: DATA_LENGTH=7 yields one 7-bit word in [6:0], bit 7 = 0.
  - des_start while busy is ignored. des_data_out holds between strobes.
  - Once IDLE is re-entered, a new run may start on the next edge.
- Waiter, states IDLE and COUNT:
  - IDLE: on an edge with wait_start=1 and wait_count_to != 0, latch wait_count_to, clear the counter, set wait_busy=1.
  - Counter increments each cycle; wait_busy clears on the edge where counter == latched-1. wait_busy is high exactly wait_count_to cycles.
  - wait_count_to = 0: no busy.
  - wait_start while busy: ignored.
  - Changes to wait_count_to during a wait: no effect.
- Debouncer:
  - pb_in passes through a 2-flop synchronizer.
  - If sync == pb_state, the counter is held at 0. Otherwise the counter increments.
  - When the counter reaches all-ones, pb_state toggles and the counter clears. The new level must persist 2^DEBOUNCE_BITS-1 cycles.
  - Any bounce back to pb_state clears the counter.
  - pb_down/pb_up are asserted in the same cycle pb_state changes (registered), for one cycle.
- The three sub-functions may run concurrently; they do not interact.

Optional Feature:
- Macro SD_RX_LSB_FIRST_EN.
- Defined: deserializer shifts right; the first received bit lands in bit 0 of the word. A partial final word is then placed in the low bits in arrival order.
- Undefined: MSB-first as above.
- The waiter and debouncer are unaffected.

Test Plan:
- Deserializer, DATA_LENGTH=16, WORD_SIZE=8, des_start pulse, serial 0xA5 then 0x3C MSB-first -> des_busy high 16 cycles; des_rco pulses after bits 8 and 16; des_data_out = 0xA5 then 0x3C; des_busy low on edge 16.
- Deserializer, DATA_LENGTH=7, serial 1,0,1,1,0,0,1 -> one des_rco on 7th bit; des_data_out = 0x59. Also assert des_start again while busy -> no restart.
- Waiter: wait_count_to=80, wait_start pulse -> wait_busy high exactly 80 cycles. wait_count_to=0 -> wait_busy never asserts. Reset at cycle 40 -> wait_busy=0 immediately.
- Debouncer, DEBOUNCE_BITS=4: pb_in toggles every 5 cycles -> pb_state stays 0. pb_in steady 1 -> pb_state rises 2 sync + 15 cycles later with one pb_down pulse. Release -> pb_up pulse.
- Concurrency/reset: deserializer and waiter started on the same edge both complete correctly. Async reset mid-capture clears des_busy, des_rco and des_data_out to 0.
- SD_RX_LSB_FIRST_EN defined: same stream as the first scenario yields bit-reversed words 0xA5 -> 0xA5 and 0x3C -> 0x3C.
